// File: rtl/fibonacci_index_finder.sv
// rtl/fibonacci_index_finder.sv - inverse Fibonacci search: value -> index, one term per clock
// Optional floor/remainder reporting enabled by defining FIBO_INV_FLOOR_EN.
module fibonacci_index_finder #(
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 5,
  parameter int MAX_IDX = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              begin_fibo,
  input  logic [DATA_W-1:0] fibo_in,
  output logic              busy,
  output logic              done,
  output logic              is_fibo,
  output logic [IDX_W-1:0]  fibo_index
`ifdef FIBO_INV_FLOOR_EN
  ,
  output logic [DATA_W-1:0] remainder
`endif
);

  localparam logic S_IDLE    = 1'b0;
  localparam logic S_COMPUTE = 1'b1;
  localparam logic [IDX_W-1:0] K_MAX = IDX_W'(MAX_IDX);

  logic              state;
  logic [DATA_W-1:0] val;
  // One extra bit so F(MAX_IDX+1) fits in b without wrapping.
  logic [DATA_W:0]   a;
  logic [DATA_W:0]   b;
  logic [IDX_W-1:0]  k;
`ifdef FIBO_INV_FLOOR_EN
  logic [DATA_W-1:0] p;
`endif

  logic [DATA_W:0] val_ext;
  assign val_ext = {1'b0, val};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      val        <= '0;
      a          <= '0;
      b          <= '0;
      k          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      is_fibo    <= 1'b0;
      fibo_index <= '0;
`ifdef FIBO_INV_FLOOR_EN
      p          <= '0;
      remainder  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (begin_fibo) begin
            val   <= fibo_in;
            a     <= '0;
            b     <= (DATA_W+1)'(1);
            k     <= '0;
            busy  <= 1'b1;
            state <= S_COMPUTE;
`ifdef FIBO_INV_FLOOR_EN
            p     <= '0;
`endif
          end
        end
        S_COMPUTE: begin
          if (a == val_ext) begin
            is_fibo    <= 1'b1;
            fibo_index <= k;
`ifdef FIBO_INV_FLOOR_EN
            remainder  <= '0;
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (a > val_ext) begin
            // Overshot: the previous term (p, index k-1) is the floor.
            is_fibo <= 1'b0;
`ifdef FIBO_INV_FLOOR_EN
            fibo_index <= k - IDX_W'(1);
            remainder  <= val - p;
`else
            fibo_index <= '0;
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (k == K_MAX) begin
            is_fibo <= 1'b0;
`ifdef FIBO_INV_FLOOR_EN
            fibo_index <= K_MAX;
            remainder  <= val - a[DATA_W-1:0];
`else
            fibo_index <= '0;
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
`ifdef FIBO_INV_FLOOR_EN
            p <= a[DATA_W-1:0];
`endif
            a <= b;
            b <= a + b;
            k <= k + IDX_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fibonacci_index_finder.sv
// tb/tb_fibonacci_index_finder.sv - table-driven scoreboard bench for fibonacci_index_finder
module tb_fibonacci_index_finder;

  typedef struct {
    logic [15:0] val;
    logic        fib;
    logic [4:0]  fidx;   // exact index, or floor index when not found
    logic [15:0] rem;
    int          lat;
    int          start;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        begin_fibo = 1'b0;
  logic [15:0] fibo_in = '0;
  logic        busy, done, is_fibo;
  logic [4:0]  fibo_index;
`ifdef FIBO_INV_FLOOR_EN
  logic [15:0] remainder;
`endif

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_count = 0;
  exp_t sb[$];
  exp_t vecs[11];
  exp_t mon_e;

  fibonacci_index_finder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .begin_fibo (begin_fibo),
    .fibo_in    (fibo_in),
    .busy       (busy),
    .done       (done),
    .is_fibo    (is_fibo),
    .fibo_index (fibo_index)
`ifdef FIBO_INV_FLOOR_EN
    ,
    .remainder  (remainder)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int exp_index(input exp_t e);
`ifdef FIBO_INV_FLOOR_EN
    return int'(e.fidx);
`else
    return e.fib ? int'(e.fidx) : 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (reset_n && done) begin
      done_count++;
      check("done_expected", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check($sformatf("is_fibo[%0d]", mon_e.val), int'(is_fibo), int'(mon_e.fib));
        check($sformatf("index[%0d]", mon_e.val), int'(fibo_index), exp_index(mon_e));
        check($sformatf("latency[%0d]", mon_e.val), cyc - mon_e.start, mon_e.lat);
`ifdef FIBO_INV_FLOOR_EN
        check($sformatf("remainder[%0d]", mon_e.val), int'(remainder), int'(mon_e.rem));
`endif
      end
    end
  end

  task automatic accept_push(input exp_t e);
    exp_t x;
    @(posedge clk);
    #1;
    x = e;
    x.start = cyc;
    sb.push_back(x);
    check($sformatf("busy_after_accept[%0d]", e.val), int'(busy), 1);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      #2;
    end
    check("done_timeout", sb.size(), 0);
  endtask

  task automatic run_vec(input exp_t e);
    @(negedge clk);
    begin_fibo = 1'b1;
    fibo_in    = e.val;
    accept_push(e);
    @(negedge clk);
    begin_fibo = 1'b0;
    fibo_in    = 16'($urandom);
    wait_empty();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_is_fibo"}, int'(is_fibo), 0);
    check({tag, "_index"}, int'(fibo_index), 0);
`ifdef FIBO_INV_FLOOR_EN
    check({tag, "_remainder"}, int'(remainder), 0);
`endif
  endtask

  initial begin
    int dc;
    exp_t e21, e22, e144, e5;
    //            val     fib  fidx  rem     lat
    vecs[0]  = '{16'd0,     1'b1, 5'd0,  16'd0,     1, 0};
    vecs[1]  = '{16'd1,     1'b1, 5'd1,  16'd0,     2, 0};
    vecs[2]  = '{16'd13,    1'b1, 5'd7,  16'd0,     8, 0};
    vecs[3]  = '{16'd14,    1'b0, 5'd7,  16'd1,     9, 0};
    vecs[4]  = '{16'd46368, 1'b1, 5'd24, 16'd0,    25, 0};
    vecs[5]  = '{16'd65535, 1'b0, 5'd24, 16'd19167, 25, 0};
    vecs[6]  = '{16'd2,     1'b1, 5'd3,  16'd0,     4, 0};
    vecs[7]  = '{16'd4,     1'b0, 5'd4,  16'd1,     6, 0};
    vecs[8]  = '{16'd100,   1'b0, 5'd11, 16'd11,   13, 0};
    vecs[9]  = '{16'd28657, 1'b1, 5'd23, 16'd0,    24, 0};
    vecs[10] = '{16'd3,     1'b1, 5'd4,  16'd0,     5, 0};
    e21  = '{16'd21,  1'b1, 5'd8,  16'd0, 9,  0};
    e22  = '{16'd22,  1'b0, 5'd8,  16'd1, 10, 0};
    e144 = '{16'd144, 1'b1, 5'd12, 16'd0, 13, 0};
    e5   = '{16'd5,   1'b1, 5'd5,  16'd0, 6,  0};

    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Begin held high: second request lands in the done cycle, later begins ignored.
    @(negedge clk);
    begin_fibo = 1'b1;
    fibo_in    = 16'd21;
    accept_push(e21);
    @(negedge clk);
    fibo_in = 16'd22;
    wait_empty();
    accept_push(e22);
    repeat (3) @(negedge clk);
    begin_fibo = 1'b0;
    wait_empty();

    run_vec(e144);

    // Abort a long search with reset: outputs clear at once, no done afterwards.
    @(negedge clk);
    begin_fibo = 1'b1;
    fibo_in    = 16'd65535;
    @(negedge clk);
    begin_fibo = 1'b0;
    repeat (4) @(negedge clk);
    dc = done_count;
    reset_n = 1'b0;
    #1;
    check_zero("abort");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check("no_done_after_abort", done_count - dc, 0);

    run_vec(e5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
